matmul_operand_feeder: RTL and testbench
========================================

# matmul_operand_feeder

Sequencer that drives the systolic matmul array: latches full A and B matrices on a start request and emits them as diagonally skewed operand wavefronts on the array's A/B edge buses. It issues the start and mode bits, then waits for the array's done. It captures the result matrix and flags, pulses a valid strobe, and flags an error if done never arrives. It is the transmitting/host-side end of the array's operand and result interface.

## Interface
- BUS_WIDTH, 16, array edge-bus width; lane count MAX_DIM = BUS_WIDTH/DATA_WIDTH (localparam, written D below).
- DATA_WIDTH, 8, operand element width (signed).
- TIMEOUT, 4*BUS_WIDTH/DATA_WIDTH, max DRAIN cycles waiting for done_i.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- start_i  in  1  job request; accepted only in IDLE.
- mode_i  in  1  accumulate-with-C select; latched at accept.
- a_mat_i  in  DATA_WIDTH*D*D  A(r,k) at element index r*D+k.
- b_mat_i  in  DATA_WIDTH*D*D  B(k,c) at element index k*D+c.
- a_o  out  BUS_WIDTH  lane r = operand entering array row r.
- b_o  out  BUS_WIDTH  lane c = operand entering array column c.
- start_bit_o  out  1  array start bit.
- mode_bit_o  out  1  array mode bit (latched mode_i).
- done_i  in  1  array done.
- res_i  in  BUS_WIDTH*D*D  array result matrix.
- flags_i  in  D*D  array overflow flags.
- res_o  out  BUS_WIDTH*D*D  captured result.
- flags_o  out  D*D  captured flags.
- valid_o  out  1  one-cycle pulse: res_o/flags_o updated.
- busy_o  out  1  job in progress.
- err_o  out  1  sticky timeout error.

## Operation
- States: IDLE, LOAD, FEED, DRAIN.
- IDLE: start_i=1 → latch a_mat_i, b_mat_i, mode_i; clear err_o; go LOAD.
- LOAD: one cycle, feed-step counter t←0; go FEED.
- FEED: 2D-1 cycles, t = 0..2D-2. Registered outputs per step:
  - a_o lane r = A(r, t-r) if 0 ≤ t-r < D, else 0.
  - b_o lane c = B(t-c, c) if 0 ≤ t-c < D, else 0.
  - start_bit_o=1 only at t=0.
- After t=2D-2, go DRAIN. a_o/b_o/start_bit_o = 0 in all states other than FEED.
- DRAIN: wait counter w counts from 0.
  - done_i=1 → on that edge res_o←res_i, flags_o←flags_i; valid_o=1 the next cycle; go IDLE.
  - w reaches TIMEOUT without done_i → err_o←1, no valid_o, go IDLE.
- done_i is ignored outside DRAIN.
- start_i is ignored while busy_o=1; no queuing.
- mode_bit_o holds the latched mode for the whole job and until the next accept.
- res_o/flags_o hold until the next capture.
- busy_o = (state != IDLE).
- Counter widths: t uses $clog2(2D-1); w uses $clog2(TIMEOUT+1), minimum 1 bit.

## Timing
- Reset (async assert, any state) → IDLE. Cleared immediately: all outputs, latched matrices, counters, err_o.
- start_i sampled at edge n:
  - busy_o=1 from n.
  - LOAD cycle n..n+1.
  - Feed step t is valid in the cycle after edge n+1+t.
- First DRAIN cycle follows edge n+2D.
- done_i=1 sampled at edge m in DRAIN → valid_o=1 and busy_o=0 in cycle m..m+1.
  - A start_i sampled at edge m+1 is accepted (back-to-back jobs).
- Reset mid-FEED or mid-DRAIN:
  - Job is aborted with no valid_o and no err_o.
  - A done_i arriving later is ignored (state IDLE).

## Test plan
- D=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], start pulse:
  - a_o = 16'h0001, 16'h0302, 16'h0400 on consecutive FEED cycles.
  - b_o = 16'h0005, 16'h0607, 16'h0800 on the same cycles.
  - start_bit_o high only on the first; then zeros.
- Same job with the array model returning res_i for [[19,22],[43,50]] and done_i 3 cycles into DRAIN:
  - Exactly one valid_o pulse with res_o = {16'd50,16'd43,16'd22,16'd19}.
  - flags_o=0; busy_o low in the valid_o cycle.
- done_i never asserted:
  - err_o=1 after exactly TIMEOUT (8) DRAIN cycles; no valid_o; busy_o falls.
  - Next accepted start_i clears err_o.
- start_i held high continuously:
  - Jobs run back-to-back with a new LOAD on the edge after each valid_o.
  - start_i mid-FEED causes no re-latch (outputs still match the first matrices).
- done_i pulsed during LOAD/FEED:
  - Ignored; no capture until a done_i arrives in DRAIN.
- rst_i asserted mid-FEED (t=1) for one cycle:
  - a_o, b_o, start_bit_o, busy_o read 0 before the next clock edge.
  - Late done_i produces no valid_o; err_o stays 0.

Source files
------------

// File: rtl/matmul_operand_feeder.sv
// matmul_operand_feeder: host-side sequencer for the systolic matmul array.
// Latches A/B on a job request, streams them as diagonally skewed wavefronts
// on the array edge buses, then waits for done and captures the result.
module matmul_operand_feeder #(
  parameter int BUS_WIDTH  = 16,
  parameter int DATA_WIDTH = 8,
  parameter int TIMEOUT    = 4*BUS_WIDTH/DATA_WIDTH
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  input  logic mode_i,
  input  logic [DATA_WIDTH*(BUS_WIDTH/DATA_WIDTH)*(BUS_WIDTH/DATA_WIDTH)-1:0] a_mat_i,
  input  logic [DATA_WIDTH*(BUS_WIDTH/DATA_WIDTH)*(BUS_WIDTH/DATA_WIDTH)-1:0] b_mat_i,
  output logic [BUS_WIDTH-1:0] a_o,
  output logic [BUS_WIDTH-1:0] b_o,
  output logic start_bit_o,
  output logic mode_bit_o,
  input  logic done_i,
  input  logic [BUS_WIDTH*(BUS_WIDTH/DATA_WIDTH)*(BUS_WIDTH/DATA_WIDTH)-1:0] res_i,
  input  logic [(BUS_WIDTH/DATA_WIDTH)*(BUS_WIDTH/DATA_WIDTH)-1:0] flags_i,
  output logic [BUS_WIDTH*(BUS_WIDTH/DATA_WIDTH)*(BUS_WIDTH/DATA_WIDTH)-1:0] res_o,
  output logic [(BUS_WIDTH/DATA_WIDTH)*(BUS_WIDTH/DATA_WIDTH)-1:0] flags_o,
  output logic valid_o,
  output logic busy_o,
  output logic err_o
);

  localparam int D      = BUS_WIDTH / DATA_WIDTH;
  localparam int MAT_W  = DATA_WIDTH * D * D;
  localparam int STEPS  = 2 * D - 1;
  localparam int T_W    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam int W_W    = (TIMEOUT + 1 > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [T_W-1:0] T_LAST = T_W'(STEPS - 1);
  localparam logic [W_W-1:0] W_LAST = W_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, LOAD, FEED, DRAIN} state_t;

  state_t         state, state_next;
  logic [T_W-1:0] t, t_next;
  logic [W_W-1:0] w, w_next;
  logic [MAT_W-1:0] a_lat, b_lat;
  logic           accept, capture, timeout;

  // Row r of the array sees A(r, t-r): row r starts r steps late.
  function automatic logic [BUS_WIDTH-1:0] skew_a(input logic [MAT_W-1:0] m,
                                                  input logic [T_W-1:0] step);
    logic [BUS_WIDTH-1:0] lanes;
    int k;
    lanes = '0;
    for (int r = 0; r < D; r++) begin
      k = int'(step) - r;
      if (k >= 0 && k < D)
        lanes[r*DATA_WIDTH +: DATA_WIDTH] = m[(r*D + k)*DATA_WIDTH +: DATA_WIDTH];
    end
    return lanes;
  endfunction

  // Column c of the array sees B(t-c, c): column c starts c steps late.
  function automatic logic [BUS_WIDTH-1:0] skew_b(input logic [MAT_W-1:0] m,
                                                  input logic [T_W-1:0] step);
    logic [BUS_WIDTH-1:0] lanes;
    int k;
    lanes = '0;
    for (int c = 0; c < D; c++) begin
      k = int'(step) - c;
      if (k >= 0 && k < D)
        lanes[c*DATA_WIDTH +: DATA_WIDTH] = m[(k*D + c)*DATA_WIDTH +: DATA_WIDTH];
    end
    return lanes;
  endfunction

  // Next-state logic and feed/drain counter updates.
  always_comb begin
    state_next = state;
    t_next     = t;
    w_next     = w;
    accept     = 1'b0;
    capture    = 1'b0;
    timeout    = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          accept     = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        t_next     = '0;
        state_next = FEED;
      end
      FEED: begin
        if (t == T_LAST) begin
          w_next     = '0;
          state_next = DRAIN;
        end else begin
          t_next = t + 1'b1;
        end
      end
      DRAIN: begin
        // A done on the final wait cycle still counts as a completed job.
        if (done_i) begin
          capture    = 1'b1;
          state_next = IDLE;
        end else if (w == W_LAST) begin
          timeout    = 1'b1;
          state_next = IDLE;
        end else begin
          w_next = w + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, counters, latched job operands and sticky error.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= IDLE;
      t          <= '0;
      w          <= '0;
      a_lat      <= '0;
      b_lat      <= '0;
      mode_bit_o <= 1'b0;
      err_o      <= 1'b0;
    end else begin
      state <= state_next;
      t     <= t_next;
      w     <= w_next;
      if (accept) begin
        a_lat      <= a_mat_i;
        b_lat      <= b_mat_i;
        mode_bit_o <= mode_i;
        err_o      <= 1'b0;
      end else if (timeout) begin
        err_o <= 1'b1;
      end
    end
  end

  // Edge buses are registered from the upcoming step so they line up with the FEED cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_o         <= '0;
      b_o         <= '0;
      start_bit_o <= 1'b0;
    end else if (state_next == FEED) begin
      a_o         <= skew_a(a_lat, t_next);
      b_o         <= skew_b(b_lat, t_next);
      start_bit_o <= (t_next == '0);
    end else begin
      a_o         <= '0;
      b_o         <= '0;
      start_bit_o <= 1'b0;
    end
  end

  // Result capture and the one-cycle valid strobe.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      res_o   <= '0;
      flags_o <= '0;
      valid_o <= 1'b0;
    end else begin
      valid_o <= capture;
      if (capture) begin
        res_o   <= res_i;
        flags_o <= flags_i;
      end
    end
  end

  assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_matmul_operand_feeder.sv
// Directed, table-driven bench for matmul_operand_feeder (D=2, TIMEOUT=8).
module tb_matmul_operand_feeder;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i, mode_i, done_i;
  logic [31:0] a_mat_i, b_mat_i;
  logic [15:0] a_o, b_o;
  logic        start_bit_o, mode_bit_o;
  logic [63:0] res_i, res_o;
  logic [3:0]  flags_i, flags_o;
  logic        valid_o, busy_o, err_o;

  matmul_operand_feeder dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .mode_i(mode_i),
    .a_mat_i(a_mat_i), .b_mat_i(b_mat_i), .a_o(a_o), .b_o(b_o),
    .start_bit_o(start_bit_o), .mode_bit_o(mode_bit_o), .done_i(done_i),
    .res_i(res_i), .flags_i(flags_i), .res_o(res_o), .flags_o(flags_o),
    .valid_o(valid_o), .busy_o(busy_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0]      a_mat;
    logic [31:0]      b_mat;
    logic             mode;
    logic [2:0][15:0] exp_a;
    logic [2:0][15:0] exp_b;
    logic [63:0]      res;
    logic [3:0]       flags;
    int               delay;
  } vec_t;

  vec_t vecs[3];
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Runs one job from accept to the valid cycle; optionally keeps start_i high
  // and swaps the matrix inputs to another vector right after the accept edge.
  task automatic run_job(input int i, input bit hold, input int swap);
    a_mat_i = vecs[i].a_mat;
    b_mat_i = vecs[i].b_mat;
    mode_i  = vecs[i].mode;
    start_i = 1'b1;
    step();
    if (!hold) start_i = 1'b0;
    if (swap >= 0) begin
      a_mat_i = vecs[swap].a_mat;
      b_mat_i = vecs[swap].b_mat;
      mode_i  = vecs[swap].mode;
    end
    chk("load_busy", busy_o, 1'b1);
    chk("load_a_zero", a_o, 16'h0);
    chk("load_err_clear", err_o, 1'b0);
    chk("load_mode", mode_bit_o, vecs[i].mode);
    for (int t = 0; t < 3; t++) begin
      step();
      chk("feed_a", a_o, vecs[i].exp_a[t]);
      chk("feed_b", b_o, vecs[i].exp_b[t]);
      chk("feed_start_bit", start_bit_o, (t == 0));
      chk("feed_mode", mode_bit_o, vecs[i].mode);
    end
    step();
    chk("drain_a_zero", a_o, 16'h0);
    chk("drain_b_zero", b_o, 16'h0);
    chk("drain_busy", busy_o, 1'b1);
    res_i   = 64'hDEAD_BEEF_DEAD_BEEF;
    flags_i = 4'hF;
    for (int k = 0; k < vecs[i].delay; k++) begin
      step();
      chk("drain_no_valid", valid_o, 1'b0);
    end
    res_i   = vecs[i].res;
    flags_i = vecs[i].flags;
    done_i  = 1'b1;
    step();
    done_i  = 1'b0;
    res_i   = 64'hDEAD_BEEF_DEAD_BEEF;
    chk("valid_pulse", valid_o, 1'b1);
    chk("valid_busy_low", busy_o, 1'b0);
    chk("res_capture", res_o, vecs[i].res);
    chk("flags_capture", flags_o, vecs[i].flags);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // A=[[1,2],[3,4]], B=[[5,6],[7,8]]
    vecs[0].a_mat = 32'h04030201;  vecs[0].b_mat = 32'h08070605;  vecs[0].mode = 1'b0;
    vecs[0].exp_a = {16'h0400, 16'h0302, 16'h0001};
    vecs[0].exp_b = {16'h0800, 16'h0607, 16'h0005};
    vecs[0].res   = {16'd50, 16'd43, 16'd22, 16'd19};
    vecs[0].flags = 4'b0000;  vecs[0].delay = 3;
    // A=[[-1,2],[3,-4]], B=[[127,-128],[1,-2]]
    vecs[1].a_mat = 32'hFC0302FF;  vecs[1].b_mat = 32'hFE01807F;  vecs[1].mode = 1'b1;
    vecs[1].exp_a = {16'hFC00, 16'h0302, 16'h00FF};
    vecs[1].exp_b = {16'hFE00, 16'h8001, 16'h007F};
    vecs[1].res   = 64'h8000_7FFF_FFFE_0003;
    vecs[1].flags = 4'b1010;  vecs[1].delay = 0;
    // A=[[0x11,0x22],[0x33,0x44]], B=[[0xAA,0xBB],[0xCC,0xDD]]
    vecs[2].a_mat = 32'h44332211;  vecs[2].b_mat = 32'hDDCCBBAA;  vecs[2].mode = 1'b0;
    vecs[2].exp_a = {16'h4400, 16'h3322, 16'h0011};
    vecs[2].exp_b = {16'hDD00, 16'hBBCC, 16'h00AA};
    vecs[2].res   = 64'h0123_4567_89AB_CDEF;
    vecs[2].flags = 4'b0001;  vecs[2].delay = 5;

    rst_i = 1'b1; start_i = 1'b0; mode_i = 1'b0; done_i = 1'b0;
    a_mat_i = '0; b_mat_i = '0; res_i = '0; flags_i = '0;
    #1;
    chk("rst_a", a_o, 16'h0);
    chk("rst_b", b_o, 16'h0);
    chk("rst_start_bit", start_bit_o, 1'b0);
    chk("rst_mode_bit", mode_bit_o, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_valid", valid_o, 1'b0);
    chk("rst_err", err_o, 1'b0);
    chk("rst_res", res_o, 64'h0);
    chk("rst_flags", flags_o, 4'h0);
    step();
    step();
    rst_i = 1'b0;
    step();

    // Table of single jobs.
    for (int i = 0; i < 3; i++) begin
      run_job(i, 1'b0, -1);
      step();
      chk("valid_once", valid_o, 1'b0);
      chk("idle_busy", busy_o, 1'b0);
    end

    // start_i held high: no re-latch mid-job, new LOAD right after valid.
    run_job(0, 1'b1, 1);
    run_job(1, 1'b0, -1);
    step();
    chk("b2b_idle", busy_o, 1'b0);

    // done_i never arrives: timeout after exactly 8 DRAIN cycles.
    a_mat_i = vecs[0].a_mat; b_mat_i = vecs[0].b_mat; mode_i = 1'b0;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    for (int t = 0; t < 3; t++) step();
    step();
    chk("to_first_drain_busy", busy_o, 1'b1);
    chk("to_first_drain_err", err_o, 1'b0);
    for (int k = 1; k < 8; k++) begin
      step();
      chk("to_wait_err", err_o, 1'b0);
      chk("to_wait_busy", busy_o, 1'b1);
    end
    step();
    chk("to_err_set", err_o, 1'b1);
    chk("to_busy_low", busy_o, 1'b0);
    chk("to_no_valid", valid_o, 1'b0);
    step();
    chk("to_err_sticky", err_o, 1'b1);
    chk("to_res_held", res_o, vecs[1].res);
    run_job(0, 1'b0, -1);
    step();

    // done_i during LOAD/FEED is ignored.
    a_mat_i = vecs[2].a_mat; b_mat_i = vecs[2].b_mat; mode_i = 1'b0;
    res_i = 64'h1111_2222_3333_4444; flags_i = 4'hF;
    done_i = 1'b1;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk("early_done_load", valid_o, 1'b0);
    for (int t = 0; t < 3; t++) begin
      step();
      chk("early_done_feed", valid_o, 1'b0);
      chk("early_done_feed_a", a_o, vecs[2].exp_a[t]);
    end
    step();
    done_i = 1'b0;
    chk("early_done_drain_valid", valid_o, 1'b0);
    chk("early_done_drain_busy", busy_o, 1'b1);
    chk("early_done_res_held", res_o, vecs[0].res);
    step();
    chk("early_done_drain2_valid", valid_o, 1'b0);
    res_i = vecs[2].res; flags_i = vecs[2].flags;
    done_i = 1'b1;
    step();
    done_i = 1'b0;
    chk("late_done_valid", valid_o, 1'b1);
    chk("late_done_res", res_o, vecs[2].res);
    chk("late_done_flags", flags_o, vecs[2].flags);
    step();

    // Reset mid-FEED at t=1 aborts the job.
    a_mat_i = vecs[0].a_mat; b_mat_i = vecs[0].b_mat; mode_i = 1'b1;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
    step();
    step();
    chk("abort_pre_a", a_o, 16'h0302);
    #2;
    rst_i = 1'b1;
    #1;
    chk("abort_a", a_o, 16'h0);
    chk("abort_b", b_o, 16'h0);
    chk("abort_start_bit", start_bit_o, 1'b0);
    chk("abort_busy", busy_o, 1'b0);
    chk("abort_res", res_o, 64'h0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    res_i = vecs[1].res;
    done_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      chk("abort_late_done_valid", valid_o, 1'b0);
      chk("abort_late_done_err", err_o, 1'b0);
      chk("abort_late_done_busy", busy_o, 1'b0);
    end
    done_i = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
